// File: rtl/alsu_result_fifo_if.sv
// rtl/alsu_result_fifo_if.sv - capture and drain handshake bundle for the ALSU result FIFO
interface alsu_result_fifo_if;
    logic              in_valid;
    logic signed [5:0] in_data;
    logic [15:0]       in_leds;
    logic              clr;
    logic              rd_ready;
    logic              rd_valid;
    logic signed [5:0] rd_data;
    logic              rd_invalid;

    modport master (
        output in_valid, in_data, in_leds, clr, rd_ready,
        input  rd_valid, rd_data, rd_invalid
    );

    modport slave (
        input  in_valid, in_data, in_leds, clr, rd_ready,
        output rd_valid, rd_data, rd_invalid
    );
endinterface

// File: rtl/alsu_result_fifo.sv
// rtl/alsu_result_fifo.sv - ALSU result capture FIFO with saturating sum and invalid counter
// Optional ALSU_FIFO_PEAK_EN adds peak_max/peak_min tracking of drained results.
module alsu_result_fifo #(
    parameter int DEPTH = 8,
    parameter int ACC_W = 12,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    alsu_result_fifo_if.slave         bus,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow,
    output logic signed [ACC_W-1:0]   acc,
`ifdef ALSU_FIFO_PEAK_EN
    output logic signed [5:0]         peak_max,
    output logic signed [5:0]         peak_min,
`endif
    output logic [CNT_W-1:0]          err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_t;

    occ_t              occ;
    logic [6:0]        mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt_q;
    logic [6:0]        head;
    logic              push;
    logic              pop;
    logic              drop;
    logic [ACC_W:0]    acc_sum;

    always_comb begin
        occ = OCC_PARTIAL;
        if (cnt_q == '0)
            occ = OCC_EMPTY;
        else if (cnt_q == CW'(DEPTH))
            occ = OCC_FULL;
    end

    assign count = cnt_q;
    assign empty = (occ == OCC_EMPTY);
    assign full  = (occ == OCC_FULL);

    // Head is forced to zero when empty so stale storage never leaks out.
    assign head           = empty ? 7'd0 : mem[rd_ptr];
    assign bus.rd_valid   = !empty;
    assign bus.rd_data    = head[5:0];
    assign bus.rd_invalid = head[6];

    assign pop  = bus.rd_valid & bus.rd_ready;
    assign push = bus.in_valid & (!full | pop);
    assign drop = bus.in_valid & full & !pop;

    // One extra bit exposes signed overflow of the running sum.
    assign acc_sum = {acc[ACC_W-1], acc} + {{(ACC_W-5){head[5]}}, head[5:0]};

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {|bus.in_leds, bus.in_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_q    <= '0;
            overflow <= 1'b0;
            acc      <= '0;
            err_cnt  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase

            if (bus.clr) begin
                overflow <= 1'b0;
                acc      <= '0;
                err_cnt  <= '0;
            end else begin
                if (drop)
                    overflow <= 1'b1;
                if (pop) begin
                    if (acc_sum[ACC_W] != acc_sum[ACC_W-1])
                        acc <= acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                              : {1'b0, {(ACC_W-1){1'b1}}};
                    else
                        acc <= acc_sum[ACC_W-1:0];
                end
                if (push && (|bus.in_leds) && (err_cnt != '1))
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end

`ifdef ALSU_FIFO_PEAK_EN
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            peak_max <= -6'sd32;
            peak_min <= 6'sd31;
        end else if (pop) begin
            if (bus.rd_data > peak_max)
                peak_max <= bus.rd_data;
            if (bus.rd_data < peak_min)
                peak_min <= bus.rd_data;
        end
    end
`endif
endmodule

// File: tb/tb_alsu_result_fifo.sv
// tb/tb_alsu_result_fifo.sv - randomized scoreboard bench for alsu_result_fifo
module tb_alsu_result_fifo;
    localparam int DEPTH = 8;
    localparam int ACC_W = 12;
    localparam int CNT_W = 8;
    localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN = -(1 << (ACC_W - 1));
    localparam int ERR_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [$clog2(DEPTH):0]  count;
    logic                    full;
    logic                    empty;
    logic                    overflow;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        err_cnt;
`ifdef ALSU_FIFO_PEAK_EN
    logic signed [5:0]       peak_max;
    logic signed [5:0]       peak_min;
`endif

    alsu_result_fifo_if bus ();

    alsu_result_fifo #(.DEPTH(DEPTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .acc      (acc),
`ifdef ALSU_FIFO_PEAK_EN
        .peak_max (peak_max),
        .peak_min (peak_min),
`endif
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit inv;
    } ent_t;

    int   total = 0;
    int   bad = 0;
    ent_t m_q[$];
    ent_t sb_q[$];
    int   m_acc = 0;
    int   m_err = 0;
    bit   m_ovf = 0;
    int   m_pmax = -32;
    int   m_pmin = 31;
    bit   started = 0;
    int   seq = 1;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue plus arithmetic bookkeeping, updated per clock edge.
    always @(posedge clk) begin
        bit   do_pop;
        bit   do_push;
        ent_t e;
        int   d;
        if (rst) begin
            m_q.delete();
            sb_q.delete();
            m_acc = 0;
            m_err = 0;
            m_ovf = 0;
            m_pmax = -32;
            m_pmin = 31;
        end else begin
            do_pop  = (m_q.size() > 0) && bus.rd_ready;
            do_push = bus.in_valid && ((m_q.size() < DEPTH) || do_pop);
            e.data  = int'(bus.in_data);
            e.inv   = (bus.in_leds != 16'd0);
            if (do_pop) begin
                d = m_q[0].data;
                m_q.pop_front();
                m_acc = m_acc + d;
                if (m_acc > ACC_MAX) m_acc = ACC_MAX;
                if (m_acc < ACC_MIN) m_acc = ACC_MIN;
                if (d > m_pmax) m_pmax = d;
                if (d < m_pmin) m_pmin = d;
            end
            if (do_push) begin
                m_q.push_back(e);
                sb_q.push_back(e);
                if (e.inv && m_err < ERR_MAX) m_err++;
            end
            if (bus.in_valid && !do_push) m_ovf = 1;
            if (bus.clr) begin
                m_acc = 0;
                m_err = 0;
                m_ovf = 0;
                m_pmax = -32;
                m_pmin = 31;
            end
        end
        started = 1;
    end

    // Monitor: status against the model, drained entries against the scoreboard.
    always @(negedge clk) begin
        if (started) begin
            chk("count", count, m_q.size());
            chk("full", full, m_q.size() == DEPTH);
            chk("empty", empty, m_q.size() == 0);
            chk("rd_valid", bus.rd_valid, m_q.size() > 0);
            chk("overflow", overflow, m_ovf);
            chk("acc", acc, m_acc);
            chk("err_cnt", err_cnt, m_err);
            chk("head_data", bus.rd_data, (m_q.size() > 0) ? m_q[0].data : 0);
            chk("head_inv", bus.rd_invalid, (m_q.size() > 0) ? m_q[0].inv : 0);
`ifdef ALSU_FIFO_PEAK_EN
            chk("peak_max", peak_max, m_pmax);
            chk("peak_min", peak_min, m_pmin);
`endif
            if (bus.rd_valid && bus.rd_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    chk("pop_data", bus.rd_data, sb_q[0].data);
                    chk("pop_inv", bus.rd_invalid, sb_q[0].inv);
                    sb_q.pop_front();
                end
            end
        end
    end

    // dm: 0 random, 1 always +31, 2 always -32, 3 incrementing 1,2,3...
    task automatic phase(input int n, input int pv, input int pr, input int dm,
                         input int pinv, input int pclr, input int prst);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.in_valid = ($urandom_range(99) < pv);
            case (dm)
                1:       bus.in_data = 6'sd31;
                2:       bus.in_data = -6'sd32;
                3: begin
                    bus.in_data = 6'(seq);
                    if (bus.in_valid) seq++;
                end
                default: bus.in_data = 6'($urandom_range(63));
            endcase
            bus.in_leds  = ($urandom_range(99) < pinv) ? 16'($urandom_range(65535, 1)) : 16'd0;
            bus.rd_ready = ($urandom_range(99) < pr);
            bus.clr      = ($urandom_range(99) < pclr);
            rst          = ($urandom_range(99) < prst);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 6'sd0;
        bus.in_leds  = 16'd0;
        bus.clr      = 1'b0;
        bus.rd_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        phase(10, 100, 0, 3, 0, 0, 0);     // fill 1..8, then overflow
        phase(10, 0, 100, 0, 0, 0, 0);     // drain in order
        phase(1, 0, 0, 0, 0, 100, 0);      // clr pulse
        phase(8, 100, 0, 0, 0, 0, 0);      // refill
        phase(20, 100, 100, 0, 30, 0, 0);  // push+pop while full
        phase(100, 100, 100, 1, 0, 0, 0);  // positive saturation
        phase(200, 100, 100, 2, 0, 0, 0);  // negative saturation
        phase(400, 90, 70, 0, 100, 0, 0);  // err_cnt saturation
        phase(4, 100, 0, 0, 20, 0, 0);     // queue four entries
        phase(1, 0, 100, 0, 0, 0, 100);    // reset during pop
        phase(3, 0, 0, 0, 0, 0, 0);
        phase(2000, 55, 50, 0, 30, 2, 1);  // random mix
        phase(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alsu_result_fifo.md
Name: alsu_result_fifo

Overview:
Downstream capture stage for the ALSU result path. It samples the ALSU's registered signed 6-bit result and 16-bit LED word on qualified cycles and queues them in a small FIFO. It drains the queue to a consumer over a valid/ready handshake, keeping a saturating signed running sum of drained results and a count of invalid-flagged captures. It sits between the ALSU output registers and the checker/scoreboard logic.

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2
ACC_W, 12, width of signed running sum
CNT_W, 8, width of invalid-capture counter

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  capture qualifier for current in_data/in_leds
in_data  in  6  signed ALSU result
in_leds  in  16  ALSU LED word; nonzero marks the capture as invalid
clr  in  1  synchronous clear of acc, err_cnt, overflow (FIFO untouched)
rd_ready  in  1  consumer accepts head entry
rd_valid  out  1  head entry available
rd_data  out  6  signed head result
rd_invalid  out  1  head entry's invalid flag
count  out  $clog2(DEPTH)+1  current occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow  out  1  sticky: push dropped while full
acc  out  ACC_W  signed saturating sum of popped rd_data
err_cnt  out  CNT_W  saturating count of pushes with invalid flag

Behaviour:
- Reset (rst=1 at clk edge): pointers=0, count=0, empty=1, full=0, rd_valid=0, rd_data=0, rd_invalid=0, overflow=0, acc=0, err_cnt=0. Reset takes priority over all other inputs, including mid-drain. Queued entries are discarded.
- Entry = {invalid_flag = |in_leds, in_data}, 7 bits.
- Push: in_valid=1 and (not full, or pop in same cycle). Written at the edge. Visible at rd_valid on the next cycle at the earliest; no same-cycle bypass.
- Pop: rd_valid & rd_ready. The head advances at the edge. rd_data/rd_invalid always show the current head (combinational read of registered storage). They read 0 when empty.
- Simultaneous push and pop: both occur and count is unchanged. This is legal when full, and it does not set overflow.
- Push while full without pop: entry dropped, overflow set to 1 and held until clr or rst.
- Pop while empty: impossible, since rd_valid=0. rd_ready is ignored.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- acc: on each pop, acc <= sat(acc + sign_extend(rd_data)). Saturation limits are +(2^(ACC_W-1)-1) and -2^(ACC_W-1).
- err_cnt: +1 on each accepted push with invalid_flag=1. Holds at 2^CNT_W-1. Dropped pushes are not counted.
- clr: acc, err_cnt and overflow are set to 0 at the edge. clr wins over a same-cycle pop or push update to those registers. FIFO contents, push and pop proceed normally.
- No state machine beyond FIFO occupancy. State is count in {EMPTY, PARTIAL, FULL}, derived from count.

Optional Feature:
ALSU_FIFO_PEAK_EN:
- Defined: adds outputs peak_max and peak_min (6-bit signed each). They track the maximum and minimum popped rd_data since reset or clr. Reset/clr values are peak_max=-32 and peak_min=+31. They update at the pop edge.
- Undefined: these ports and their registers are absent, and all other behaviour is identical.

Test Plan:
- Reset then fill: push 8 entries (1..8) with rd_ready=0 and in_leds=0 -> full=1, count=8, rd_data=1; a 9th push sets overflow=1 and count stays 8.
- Drain order: rd_ready=1 for 8 cycles after fill -> rd_data sequence 1..8, acc=36, empty=1, rd_valid=0; overflow remains 1 until clr pulse -> 0.
- Simultaneous push/pop when full: full FIFO, in_valid=1 with in_data=-5 and rd_ready=1 -> count stays 8, overflow stays 0, -5 appears as the last entry.
- Invalid tagging: push in_data=0 with in_leds=16'hFFFF, then in_data=3 with in_leds=0 -> rd_invalid=1 then 0, err_cnt=1.
- Saturation: push 31 repeatedly with continuous pop (ACC_W=12) -> acc clamps at 2047; with -32 repeatedly -> acc clamps at -2048.
- Reset mid-operation: 4 entries queued, rst=1 for one cycle during a pop -> count=0, acc=0, err_cnt=0, rd_valid=0 next cycle; with ALSU_FIFO_PEAK_EN, peak_max=-32 and peak_min=31.
